// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready FIFO feeding a back-to-back frame serialiser.
// Optional macro UART_TX_CTS_EN adds the active-low clear-to-send input i_uart_cts_n.
module uart_tx_fifo #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BURD_RATE  = 115200,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_CHECK_ON   = 0,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_FIFO_DEPTH      = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [P_UART_DATA_WIDTH-1:0]       i_user_tx_data,
  input  logic                               i_user_tx_valid,
`ifdef UART_TX_CTS_EN
  input  logic                               i_uart_cts_n,
`endif
  output logic                               o_user_tx_ready,
  output logic                               o_uart_tx,
  output logic                               o_tx_busy,
  output logic [$clog2(P_FIFO_DEPTH):0]      o_fifo_level,
  output logic                               o_fifo_empty
);

  localparam int P_BAUD_DIV = P_SYSTEM_CLK / P_UART_BURD_RATE;
  localparam int PTR_W      = $clog2(P_FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;
  localparam int CNT_W      = (P_BAUD_DIV > 1) ? $clog2(P_BAUD_DIV) : 1;
  localparam int BIT_W      = $clog2(P_UART_DATA_WIDTH);
  localparam int DW         = P_UART_DATA_WIDTH;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(P_BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(P_UART_DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(P_UART_STOP_WIDTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(P_FIFO_DEPTH);

  if (P_BAUD_DIV < 2) begin : g_baud_div_check
    $error("uart_tx_fifo: P_SYSTEM_CLK / P_UART_BURD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit that completes the data word to odd or even weight.
  function automatic logic calc_parity(input logic [DW-1:0] data);
    if (P_UART_CHECK_ON == 1) begin
      return ~^data;
    end else if (P_UART_CHECK_ON == 2) begin
      return ^data;
    end else begin
      return 1'b0;
    end
  endfunction

  logic [DW-1:0]    mem_r [P_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] count_r;
  logic             full_s, empty_s, push_s, pop_s, cts_ok_s, start_ok_s, baud_last_s;
  logic [DW-1:0]    head_s;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] baud_r, baud_nxt_s;
  logic [BIT_W-1:0] bit_r, bit_nxt_s;
  logic [DW-1:0]    shift_r, shift_nxt_s;
  logic             parity_r, parity_nxt_s, tx_r, tx_nxt_s, busy_r;

`ifdef UART_TX_CTS_EN
  assign cts_ok_s = ~i_uart_cts_n;
`else
  assign cts_ok_s = 1'b1;
`endif

  assign full_s      = (count_r == FULL_LVL);
  assign empty_s     = (count_r == LVL_W'(0));
  assign push_s      = i_user_tx_valid & ~full_s;
  assign head_s      = mem_r[rd_ptr_r];
  assign start_ok_s  = ~empty_s & cts_ok_s;
  assign baud_last_s = (baud_r == BAUD_LAST);

  assign o_user_tx_ready = ~full_s;
  assign o_fifo_level    = count_r;
  assign o_fifo_empty    = empty_s;
  assign o_uart_tx       = tx_r;
  assign o_tx_busy       = busy_r;

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_user_tx_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LVL_W'(1);
        2'b01:   count_r <= count_r - LVL_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencing; tx_nxt_s is the line level for the state being entered.
  always_comb begin
    state_nxt_s  = state_r;
    baud_nxt_s   = baud_r;
    bit_nxt_s    = bit_r;
    shift_nxt_s  = shift_r;
    parity_nxt_s = parity_r;
    tx_nxt_s     = tx_r;
    pop_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        tx_nxt_s = 1'b1;
        if (start_ok_s) begin
          pop_s        = 1'b1;
          shift_nxt_s  = head_s;
          parity_nxt_s = calc_parity(head_s);
          baud_nxt_s   = '0;
          tx_nxt_s     = 1'b0;
          state_nxt_s  = S_START;
        end else begin
          baud_nxt_s = '0;
        end
      end
      S_START: begin
        if (baud_last_s) begin
          baud_nxt_s  = '0;
          bit_nxt_s   = '0;
          tx_nxt_s    = shift_r[0];
          state_nxt_s = S_DATA;
        end else begin
          baud_nxt_s = baud_r + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last_s) begin
          baud_nxt_s = '0;
          if (bit_r == DATA_LAST) begin
            bit_nxt_s = '0;
            if (P_UART_CHECK_ON != 0) begin
              tx_nxt_s    = parity_r;
              state_nxt_s = S_PARITY;
            end else begin
              tx_nxt_s    = 1'b1;
              state_nxt_s = S_STOP;
            end
          end else begin
            bit_nxt_s   = bit_r + BIT_W'(1);
            shift_nxt_s = {1'b0, shift_r[DW-1:1]};
            tx_nxt_s    = shift_r[1];
          end
        end else begin
          baud_nxt_s = baud_r + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_last_s) begin
          baud_nxt_s  = '0;
          bit_nxt_s   = '0;
          tx_nxt_s    = 1'b1;
          state_nxt_s = S_STOP;
        end else begin
          baud_nxt_s = baud_r + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last_s) begin
          baud_nxt_s = '0;
          if (bit_r == STOP_LAST) begin
            bit_nxt_s = '0;
            // Chain straight into the next start bit when data is waiting.
            if (start_ok_s) begin
              pop_s        = 1'b1;
              shift_nxt_s  = head_s;
              parity_nxt_s = calc_parity(head_s);
              tx_nxt_s     = 1'b0;
              state_nxt_s  = S_START;
            end else begin
              tx_nxt_s    = 1'b1;
              state_nxt_s = S_IDLE;
            end
          end else begin
            bit_nxt_s = bit_r + BIT_W'(1);
          end
        end else begin
          baud_nxt_s = baud_r + CNT_W'(1);
        end
      end
      default: begin
        baud_nxt_s  = '0;
        bit_nxt_s   = '0;
        tx_nxt_s    = 1'b1;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Serialiser state and registered line outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r  <= S_IDLE;
      baud_r   <= '0;
      bit_r    <= '0;
      shift_r  <= '0;
      parity_r <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      baud_r   <= baud_nxt_s;
      bit_r    <= bit_nxt_s;
      shift_r  <= shift_nxt_s;
      parity_r <= parity_nxt_s;
      tx_r     <= tx_nxt_s;
      busy_r   <= (state_nxt_s != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: 8N1, 8E1 and 8O2 instances, burst, reset, optional CTS.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cts_n = 1'b0;

  logic [7:0] data_a = 8'h00, data_b = 8'h00, data_c = 8'h00;
  logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] level_a, level_b, level_c;
  logic       empty_a, empty_b, empty_c;
  logic [2:0] tx_v, busy_v;

  int n_checks = 0;
  int n_pass   = 0;

  assign tx_v   = {tx_c, tx_b, tx_a};
  assign busy_v = {busy_c, busy_b, busy_a};

  always #5 clk = ~clk;

  uart_tx_fifo #(.P_SYSTEM_CLK(1_000_000), .P_UART_BURD_RATE(100_000), .P_UART_DATA_WIDTH(8),
                 .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(1), .P_FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_user_tx_data(data_a), .i_user_tx_valid(valid_a),
`ifdef UART_TX_CTS_EN
    .i_uart_cts_n(cts_n),
`endif
    .o_user_tx_ready(ready_a), .o_uart_tx(tx_a), .o_tx_busy(busy_a),
    .o_fifo_level(level_a), .o_fifo_empty(empty_a));

  uart_tx_fifo #(.P_SYSTEM_CLK(1_000_000), .P_UART_BURD_RATE(100_000), .P_UART_DATA_WIDTH(8),
                 .P_UART_CHECK_ON(2), .P_UART_STOP_WIDTH(1), .P_FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_user_tx_data(data_b), .i_user_tx_valid(valid_b),
`ifdef UART_TX_CTS_EN
    .i_uart_cts_n(1'b0),
`endif
    .o_user_tx_ready(ready_b), .o_uart_tx(tx_b), .o_tx_busy(busy_b),
    .o_fifo_level(level_b), .o_fifo_empty(empty_b));

  uart_tx_fifo #(.P_SYSTEM_CLK(1_000_000), .P_UART_BURD_RATE(100_000), .P_UART_DATA_WIDTH(8),
                 .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(2), .P_FIFO_DEPTH(4)) dut_c (
    .i_clk(clk), .i_rst(rst_n), .i_user_tx_data(data_c), .i_user_tx_valid(valid_c),
`ifdef UART_TX_CTS_EN
    .i_uart_cts_n(1'b0),
`endif
    .o_user_tx_ready(ready_c), .o_uart_tx(tx_c), .o_tx_busy(busy_c),
    .o_fifo_level(level_c), .o_fifo_empty(empty_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts sampling one clock after the start bit went out; each bit must hold for 10 clocks.
  task automatic frame_check(input int sel, input logic [15:0] bits, input int nbits, input string tag);
    for (int b = 0; b < nbits; b++) begin
      logic [1:0] obs;
      obs = {1'b1, bits[b]};
      for (int c = 0; c < 10; c++) begin
        if ({busy_v[sel[1:0]], tx_v[sel[1:0]]} !== {1'b1, bits[b]} && obs === {1'b1, bits[b]})
          obs = {busy_v[sel[1:0]], tx_v[sel[1:0]]};
        tick();
      end
      check($sformatf("%s bit%0d busy/tx", tag, b), 32'(obs), 32'({1'b1, bits[b]}));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst tx",    32'(tx_a),    32'(1));
    check("rst busy",  32'(busy_a),  32'(0));
    check("rst level", 32'(level_a), 32'(0));
    check("rst empty", 32'(empty_a), 32'(1));
    check("rst ready", 32'(ready_a), 32'(1));
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single 8N1 word 0xA5.
    data_a = 8'hA5; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    check("a5 level after push", 32'(level_a), 32'(1));
    check("a5 tx idle at k",     32'(tx_a),    32'(1));
    tick();
    check("a5 level after pop",  32'(level_a), 32'(0));
    frame_check(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, "a5");
    check("a5 busy end", 32'(busy_a),  32'(0));
    check("a5 tx end",   32'(tx_a),    32'(1));
    check("a5 empty",    32'(empty_a), 32'(1));

    // Even parity, 0x07 -> parity 1, 110 clocks.
    data_b = 8'h07; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    tick();
    frame_check(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "even");
    check("even busy end", 32'(busy_b), 32'(0));

    // Odd parity, two stop bits, 0x07 -> parity 0, 120 clocks.
    data_c = 8'h07; valid_c = 1'b1;
    tick();
    valid_c = 1'b0;
    tick();
    frame_check(2, {4'b0, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 12, "odd2");
    check("odd2 busy end", 32'(busy_c), 32'(0));

    // Burst of six words with valid held; FIFO depth 4.
    begin
      int n, push6, bad[6];
      logic acc;
      logic [9:0] fb;
      n = 1; push6 = -1;
      for (int f = 0; f < 6; f++) bad[f] = 0;
      data_a = 8'h01; valid_a = 1'b1;
      for (int t = 0; t <= 601; t++) begin
        acc = ready_a & valid_a;
        tick();
        if (acc) begin
          if (n == 6) begin
            push6 = t;
            valid_a = 1'b0;
          end
          n++;
          data_a = 8'(n);
        end
        if (t == 3) check("burst level t3", 32'(level_a), 32'(3));
        if (t == 4) begin
          check("burst level t4", 32'(level_a), 32'(4));
          check("burst ready t4", 32'(ready_a), 32'(0));
        end
        if (t >= 1 && t <= 600) begin
          fb = {1'b1, 8'((t - 1) / 100 + 1), 1'b0};
          if (tx_a !== fb[((t - 1) % 100) / 10] || busy_a !== 1'b1) bad[(t - 1) / 100]++;
        end
      end
      for (int f = 0; f < 6; f++) check($sformatf("burst frame%0d bad clocks", f), 32'(bad[f]), 32'(0));
      check("burst 6th push edge", 32'(push6),   32'(102));
      check("burst busy end",      32'(busy_a),  32'(0));
      check("burst tx end",        32'(tx_a),    32'(1));
      check("burst level end",     32'(level_a), 32'(0));
    end

    // Reset in the middle of DATA of a 3-word burst of zeros.
    data_a = 8'h00; valid_a = 1'b1;
    repeat (3) tick();
    valid_a = 1'b0;
    repeat (28) tick();
    check("mid tx low",   32'(tx_a),    32'(0));
    check("mid level",    32'(level_a), 32'(2));
    #3 rst_n = 1'b0;
    #1;
    check("mid rst tx",    32'(tx_a),    32'(1));
    check("mid rst level", 32'(level_a), 32'(0));
    check("mid rst ready", 32'(ready_a), 32'(1));
    check("mid rst busy",  32'(busy_a),  32'(0));
    rst_n = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int t = 0; t < 50; t++) begin
        tick();
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd0) bad++;
      end
      check("post rst idle bad clocks", 32'(bad), 32'(0));
    end

`ifdef UART_TX_CTS_EN
    // Clear-to-send gating.
    cts_n = 1'b1;
    data_a = 8'h3C; valid_a = 1'b1;
    tick();
    data_a = 8'h55;
    tick();
    valid_a = 1'b0;
    repeat (5) tick();
    check("cts held tx",    32'(tx_a),    32'(1));
    check("cts held busy",  32'(busy_a),  32'(0));
    check("cts held level", 32'(level_a), 32'(2));
    cts_n = 1'b0;
    tick();
    check("cts start tx",    32'(tx_a),    32'(0));
    check("cts start level", 32'(level_a), 32'(1));
    cts_n = 1'b1;
    frame_check(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, "cts");
    repeat (5) tick();
    check("cts wait busy",  32'(busy_a),  32'(0));
    check("cts wait tx",    32'(tx_a),    32'(1));
    check("cts wait level", 32'(level_a), 32'(1));
    cts_n = 1'b0;
    tick();
    check("cts second start", 32'(tx_a), 32'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered, fully parametrised UART transmitter.
- Runs directly on the system clock using an internal baud-tick counter; there is no divided user clock.
- Accepts words over a valid/ready handshake into a FIFO and serialises them back-to-back.
- Configurable data width, parity mode, stop bits and FIFO depth.
- Replaces the unbuffered TX path of uart_drive wherever user logic needs to burst data.

Parameters:
- P_SYSTEM_CLK, 50_000_000: system clock frequency in Hz.
- P_UART_BURD_RATE, 115200: baud rate in bit/s.
- P_UART_DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- P_UART_CHECK_ON, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- P_UART_STOP_WIDTH, 1: stop bits; legal values 1 or 2.
- P_FIFO_DEPTH, 16: FIFO entries; power of 2, minimum 2.
- Derived localparam P_BAUD_DIV = P_SYSTEM_CLK / P_UART_BURD_RATE, integer truncation. Must be >= 2; otherwise elaboration fails with $error.

Ports:
- i_clk, in, 1: system clock; all logic on the rising edge.
- i_rst, in, 1: asynchronous, active-low reset.
- i_user_tx_data, in, P_UART_DATA_WIDTH: word to transmit.
- i_user_tx_valid, in, 1: i_user_tx_data is valid.
- o_user_tx_ready, out, 1: FIFO not full; a push occurs on the edge where valid & ready.
- o_uart_tx, out, 1: serial line; idles high; registered.
- o_tx_busy, out, 1: high while a frame is on the line (state != IDLE).
- o_fifo_level, out, $clog2(P_FIFO_DEPTH)+1: current FIFO occupancy.
- o_fifo_empty, out, 1: o_fifo_level == 0.
- i_uart_cts_n, in, 1: clear-to-send, active-low. Present only with UART_TX_CTS_EN.

Behaviour:
Reset values:
- Asserting i_rst low immediately (asynchronously) forces: o_uart_tx=1, o_tx_busy=0, o_fifo_level=0, o_fifo_empty=1, o_user_tx_ready=1.
- FIFO pointers, baud counter and bit counter clear; FSM enters IDLE.
- Reset mid-frame aborts the frame and discards all FIFO contents. No partial-frame recovery.

FIFO:
- Registered count with wrap-around read/write pointers; pointer width is $clog2(P_FIFO_DEPTH).
- o_user_tx_ready = !full, combinational from the registered count.
- Push when valid is asserted while full is ignored; data is not lost, because the producer must hold valid.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Pop from a full FIFO raises ready on the following cycle.

FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: o_uart_tx=1. If FIFO non-empty (and CTS permits), pop the head into the shift register, drive o_uart_tx=0, go to START.
- Every non-IDLE bit lasts exactly P_BAUD_DIV clocks. The baud counter runs 0..P_BAUD_DIV-1; the state or bit advances when the count reaches P_BAUD_DIV-1.
- DATA: LSB first; P_UART_DATA_WIDTH bits.
- PARITY: entered only if P_UART_CHECK_ON != 0.
  - Odd: parity bit makes the total count of ones in data+parity odd.
  - Even: parity bit makes that count even.
- STOP: o_uart_tx=1 for P_UART_STOP_WIDTH*P_BAUD_DIV clocks. At the end of STOP:
  - FIFO non-empty (and CTS permits): pop and go directly to START with no idle gap.
  - Otherwise: go to IDLE.

Latency and timing:
- A word pushed at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1, and o_uart_tx falls at edge k+1.
- Frame length = (1 + P_UART_DATA_WIDTH + (P_UART_CHECK_ON!=0) + P_UART_STOP_WIDTH) * P_BAUD_DIV clocks.

Optional Feature:
UART_TX_CTS_EN
- Defined: the i_uart_cts_n port exists. A new frame starts (from IDLE or from end of STOP) only when i_uart_cts_n is sampled 0. A frame already in progress always completes regardless of CTS. While CTS is deasserted, the FSM sits in IDLE with o_uart_tx=1 and the FIFO keeps accepting pushes.
- Undefined: the port is absent and CTS is treated as permanently asserted.

Test Plan:
All scenarios use P_SYSTEM_CLK=1_000_000, P_UART_BURD_RATE=100_000 (P_BAUD_DIV=10) and P_FIFO_DEPTH=4 unless stated.
- Single 8N1 word 0xA5 pushed at edge k -> o_uart_tx low at k+1 for 10 clocks; then bits 1,0,1,0,0,1,0,1 at 10 clocks each; high at k+91; o_tx_busy falls at k+101; o_fifo_level returns to 0.
- Parity, data 0x07: P_UART_CHECK_ON=2 -> parity bit 1; P_UART_CHECK_ON=1 -> parity bit 0; frame 110 clocks; P_UART_STOP_WIDTH=2 -> 120 clocks.
- Burst: valid held high for 6 words 0x01..0x06 starting at edge k while idle -> 0x01 popped at k+1; level reaches 4 after the 5th push; ready low and the 6th word stalls until 0x01's frame ends; all 6 frames contiguous (600 clocks, no gaps); line carries the data in order.
- Reset: i_rst driven low mid-DATA of a 3-word burst -> o_uart_tx=1, level=0, ready=1 with no clock edge; after release the line stays idle.
- UART_TX_CTS_EN: i_uart_cts_n=1, push 0x3C -> line idle, level=1. Drop CTS -> frame starts on the next edge. Raise CTS mid-frame -> frame completes; a queued second word waits.
